// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture: samples a multiplexed active-low 7-segment display bus and
// captures a decoded code for each digit position once its strobe has been stable.
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   seg_n[6:0]    - active-low segments, bit0=a .. bit6=g
//   an_n[N-1:0]   - active-low anode strobes, one low bit selects a digit
//   clear         - synchronous clear of all captured state
//   digits        - 4-bit code per position, position i at [4i+3:4i]
//   digit_err     - per position: last capture was an illegal pattern
//   blank         - per position: last capture was all segments off
//   frame_valid   - one-cycle pulse after every position has been captured
//   out_valid     - level, set once a full frame has been captured
//   anode_err     - sticky, set when a multi-hot strobe is sampled
module seg7_scan_capture #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg_n,
    input  logic [NUM_DIGITS-1:0]   an_n,
    input  logic                    clear,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   digit_err,
    output logic [NUM_DIGITS-1:0]   blank,
    output logic                    frame_valid,
    output logic                    out_valid,
    output logic                    anode_err
);
    localparam logic [3:0] CNT_MAX = 4'(STABLE_CYCLES);
    localparam logic [3:0] CNT_HIT = 4'(STABLE_CYCLES - 1);

    logic [6:0]              s_seg_q, s_seg_d;
    logic [NUM_DIGITS-1:0]   s_an_q, s_an_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [NUM_DIGITS-1:0]   seen_q, seen_d;
    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0]   err_q, err_d;
    logic [NUM_DIGITS-1:0]   blank_q, blank_d;
    logic                    fv_q, fv_d;
    logic                    ov_q, ov_d;
    logic                    aerr_q, aerr_d;
    logic [NUM_DIGITS-1:0]   sel, seen_nx;
    logic                    one_hot, multi_hot, same, capture;
    logic [3:0]              code;
    logic                    is_blank, is_err;

    always_comb begin
        is_blank = 1'b0;
        is_err   = 1'b0;
        case (seg_n)
            7'b1000000: code = 4'd0;
            7'b1111001: code = 4'd1;
            7'b0100100: code = 4'd2;
            7'b0110000: code = 4'd3;
            7'b0011001: code = 4'd4;
            7'b0010010: code = 4'd5;
            7'b0000010: code = 4'd6;
            7'b1111000: code = 4'd7;
            7'b0000000: code = 4'd8;
            7'b0010000: code = 4'd9;
            7'b1111111: begin
                code     = 4'hF;
                is_blank = 1'b1;
            end
            default: begin
                code   = 4'hE;
                is_err = 1'b1;
            end
        endcase
    end

    always_comb begin
        sel       = ~an_n;
        // x & (x-1) strips the lowest set bit; zero result means at most one bit set
        one_hot   = (sel != '0) && ((sel & (sel - NUM_DIGITS'(1))) == '0);
        multi_hot = (sel != '0) && !one_hot;
        same      = {seg_n, an_n} == {s_seg_q, s_an_q};
        capture   = same && one_hot && (cnt_q == CNT_HIT);
        seen_nx   = seen_q | sel;
        s_seg_d   = seg_n;
        s_an_d    = an_n;
        // saturation at CNT_MAX keeps a long dwell from capturing again
        cnt_d     = (same && one_hot) ? ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + 4'd1) : 4'd0;
        seen_d    = seen_q;
        digits_d  = digits_q;
        err_d     = err_q;
        blank_d   = blank_q;
        fv_d      = 1'b0;
        ov_d      = ov_q;
        aerr_d    = aerr_q | multi_hot;
        if (capture) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (sel[i]) begin
                    digits_d[4*i +: 4] = code;
                    err_d[i]           = is_err;
                    blank_d[i]         = is_blank;
                end
            end
            seen_d = (seen_nx == '1) ? '0 : seen_nx;
            fv_d   = (seen_nx == '1);
            ov_d   = ov_q | (seen_nx == '1);
        end
        // clear overrides everything, including a capture on the same edge
        if (clear) begin
            cnt_d    = 4'd0;
            seen_d   = '0;
            digits_d = {NUM_DIGITS{4'hF}};
            err_d    = '0;
            blank_d  = '1;
            fv_d     = 1'b0;
            ov_d     = 1'b0;
            aerr_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_seg_q  <= 7'h7F;
            s_an_q   <= '1;
            cnt_q    <= 4'd0;
            seen_q   <= '0;
            digits_q <= {NUM_DIGITS{4'hF}};
            err_q    <= '0;
            blank_q  <= '1;
            fv_q     <= 1'b0;
            ov_q     <= 1'b0;
            aerr_q   <= 1'b0;
        end else begin
            s_seg_q  <= s_seg_d;
            s_an_q   <= s_an_d;
            cnt_q    <= cnt_d;
            seen_q   <= seen_d;
            digits_q <= digits_d;
            err_q    <= err_d;
            blank_q  <= blank_d;
            fv_q     <= fv_d;
            ov_q     <= ov_d;
            aerr_q   <= aerr_d;
        end
    end

    assign digits      = digits_q;
    assign digit_err   = err_q;
    assign blank       = blank_q;
    assign frame_valid = fv_q;
    assign out_valid   = ov_q;
    assign anode_err   = aerr_q;
endmodule

// File: doc/seg7_scan_capture.md
SEG7_SCAN_CAPTURE -- requirements
Module: seg7_scan_capture

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed digit positions (1..8).
REQ-002 Parameter STABLE_CYCLES, default 2: consecutive identical samples required before a capture (1..15).
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 seg_n  in  7  active-low segment bus; bit0=a ... bit6=g (0 = segment lit).
REQ-006 an_n  in  NUM_DIGITS  active-low anode select; exactly one low bit = valid digit strobe.
REQ-007 clear  in  1  synchronous clear of captured state.
REQ-008 digits  out  4*NUM_DIGITS  decoded code per position; position i at bits [4i+3:4i].
REQ-009 digit_err  out  NUM_DIGITS  per-position flag: last capture was an illegal pattern.
REQ-010 blank  out  NUM_DIGITS  per-position flag: last capture was all segments off.
REQ-011 frame_valid  out  1  one-cycle pulse when every position has been captured since the previous pulse.
REQ-012 out_valid  out  1  level; high once a full frame has been captured.
REQ-013 anode_err  out  1  sticky flag: multi-hot an_n sampled.

Function
REQ-014 Decode table (seg_n -> code) SHALL be: 1000000->0, 1111001->1, 0100100->2, 0110000->3, 0011001->4, 0010010->5, 0000010->6, 1111000->7, 0000000->8, 0010000->9.
REQ-015 Pattern 1111111 SHALL decode to 4'hF with blank set and digit_err clear for that position.
REQ-016 Any other pattern SHALL decode to 4'hE with digit_err set and blank clear for that position.
REQ-017 Legal patterns SHALL clear both digit_err and blank for that position.
REQ-018 Held sample registers s_seg and s_an SHALL load seg_n and an_n on every edge.
REQ-019 Stability counter cnt (saturating at STABLE_CYCLES) SHALL increment when incoming {seg_n,an_n} equals {s_seg,s_an} and an_n is one-hot; otherwise it SHALL load 0.
REQ-020 A capture SHALL occur on the edge where incoming equals held, an_n is one-hot, and cnt == STABLE_CYCLES-1; digits/flags for the selected position update on that edge.
REQ-021 Latency: with input stable from before edge E0, the captured value SHALL be visible after edge E(STABLE_CYCLES).
REQ-022 At most one capture per dwell; saturation of cnt prevents repeats until the input changes.
REQ-023 an_n all ones SHALL produce no capture and no error.
REQ-024 an_n with two or more low bits SHALL produce no capture and SHALL set anode_err on that edge.
REQ-025 A seen mask (NUM_DIGITS bits) SHALL set the captured position's bit on each capture.
REQ-026 When a capture completes the mask (seen | new bit == all ones), frame_valid SHALL be high for the following cycle only, the mask SHALL clear on that edge, and out_valid SHALL set.
REQ-027 Re-capture of an already-seen position SHALL update its digit without affecting frame completion.
REQ-028 clear SHALL, on its edge, apply the reset values of REQ-030, except s_seg and s_an, which load normally.
REQ-029 When clear and a capture coincide on the same edge, clear SHALL win and the capture is dropped.

Reset
REQ-030 While rst_n is low: digits = all 4'hF, blank = all ones, digit_err = 0, frame_valid = 0, out_valid = 0, anode_err = 0, seen = 0, cnt = 0, s_seg = 7'h7F, s_an = all ones.
REQ-031 Reset asserted mid-dwell or mid-frame SHALL discard partial progress; after deassertion, capture resumes per REQ-019/020 from cnt = 0.

Verification (NUM_DIGITS=4, STABLE_CYCLES=2)
REQ-032 an_n=1110, seg_n=0100100 held 3 edges -> digits[3:0]=2 after 3rd edge; blank[0]=0; no frame_valid.
REQ-033 Scan positions 0..3 with codes 1,2,3,4, 3 edges each -> digits=16'h4321; frame_valid pulses exactly one cycle after position-3 capture; out_valid=1.
REQ-034 an_n=1101, seg_n=0101010 -> digits[7:4]=E, digit_err[1]=1; then seg_n=1111111 on same position -> digits[7:4]=F, blank[1]=1, digit_err[1]=0.
REQ-035 seg_n toggling every edge on position 2 -> no capture, digits unchanged; an_n=1001 for 1 edge -> anode_err=1 and stays set.
REQ-036 clear asserted on the edge of a pending capture -> capture dropped, all outputs at reset values; rst_n pulsed low mid-frame -> seen cleared; the next full scan yields exactly one frame_valid.
